output_packer: RTL and testbench
================================

OUTPUT_PACKER -- requirements
Module: output_packer

Interface
REQ-001 The block SHALL have parameter ELEM_W, default 8, giving the width of one result element in bits.
REQ-002 The block SHALL have parameter LANES, default 16, giving the number of elements per write word.
REQ-003 The block SHALL have parameter ADDR_W, default 16, giving the write address width.
REQ-004 The block SHALL have one clock and an asynchronous, active-low reset, with ports named as follows.
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
REQ-005 The block SHALL have the following ports.
- start_in  input  1  frame enable; a rising edge starts a frame.
- base_addr  input  ADDR_W  first write address of the frame.
- result_valid  input  1  result_in holds a valid element.
- result_in  input  ELEM_W  result element.
- last_in  input  1  qualifies result_in as the final element of the frame.
- result_ready  output  1  the block can accept an element.
- write_bus  output  ELEM_W*LANES  packed write word.
- write_addr  output  ADDR_W  write address.
- write_mask  output  LANES  per-lane valid bits.
- write_enable  output  1  write request.
- write_ready  input  1  memory accepts the write.
- done  output  1  one-cycle pulse at frame completion.

Function
REQ-006 The block SHALL implement states IDLE, FILL, WRITE and DONE.
REQ-007 In IDLE, on a start_in rising edge (registered start_in low, current start_in high), the block SHALL do all of the following and enter FILL next cycle:
- load the address register from base_addr;
- set the lane pointer to LANES-1;
- clear the buffer and mask.
REQ-008 In FILL, result_ready SHALL be 1; in all other states it SHALL be 0.
REQ-009 An element SHALL be accepted only in a cycle where result_valid and result_ready are both 1.
REQ-010 An accepted element SHALL be stored at bits [ptr*ELEM_W +: ELEM_W], and mask bit ptr SHALL be set.
REQ-011 Lanes SHALL fill in descending order: the first element goes to lane LANES-1 and the last to lane 0.
REQ-012 If the accepted element has ptr==0 or last_in==1, the block SHALL enter WRITE; otherwise ptr SHALL decrement.
REQ-013 In WRITE, the block SHALL drive write_enable=1 together with the packed buffer, address register and mask, starting the cycle after the completing accept.
REQ-014 Unfilled lanes SHALL read zero on write_bus, with their mask bits 0.
REQ-015 In WRITE, write_bus, write_addr and write_mask SHALL stay stable until write_ready=1.
REQ-016 On the write_ready handshake, the address SHALL increment by 1 modulo 2^ADDR_W, and the buffer and mask SHALL clear.
REQ-017 After the write handshake, the block SHALL enter DONE if the word contained the last element; otherwise it SHALL enter FILL with ptr=LANES-1.
REQ-018 In DONE, done SHALL be 1 for exactly one cycle, and the block SHALL then return to IDLE.
REQ-019 A new frame SHALL require a new start_in rising edge.
REQ-020 When write_enable=0, write_bus, write_addr and write_mask SHALL be 0.
REQ-021 If start_in falls in FILL, the block SHALL go to IDLE next cycle, discard the partial word, issue no write and not pulse done.
REQ-022 If start_in falls in WRITE, the pending write SHALL complete normally, and the block SHALL then go to IDLE without pulsing done.
REQ-023 If last_in arrives on the element where ptr==0, the block SHALL issue exactly one write with a full mask, not an additional empty write.
REQ-024 result_valid while result_ready=0 SHALL be ignored; holding the element is the producer's responsibility.
REQ-025 Minimum throughput SHALL be LANES elements per LANES+1 cycles, with write_ready tied high.

Reset
REQ-026 While reset_n=0, the block SHALL asynchronously do all of the following:
- set state to IDLE;
- set ptr to LANES-1;
- set the address register, buffer and mask to 0;
- set every output (result_ready, write_bus, write_addr, write_mask, write_enable, done) to 0.
REQ-027 The registered start_in SHALL reset to 0, so a start_in held high through reset release starts a frame on the first clock.
REQ-028 A reset in any state, including WRITE with a pending write, SHALL abandon the frame with no write and no done.

Verification (default parameters)
REQ-029 The bench SHALL cover a single full word:
- stimulus: base_addr=0x8000, elements 0x00..0x0F back-to-back, last_in on 0x0F, write_ready=1;
- response: one write at 0x8000 with bus[127:120]=0x00 through bus[7:0]=0x0F, mask 0xFFFF, then a done pulse.
REQ-030 The bench SHALL cover a partial final word:
- stimulus: base_addr=0x0100, 20 elements, last_in on the 20th;
- response: a write at 0x0100 with mask 0xFFFF, then a write at 0x0101 with mask 0xF000 and bus[95:0]=0.
REQ-031 The bench SHALL cover backpressure:
- stimulus: write_ready held 0 for 5 cycles during WRITE;
- response: write_bus, write_addr and write_mask stay constant, result_ready stays 0, and all elements appear intact in later words.
REQ-032 The bench SHALL cover address wrap:
- stimulus: base_addr=0xFFFF, 32 elements;
- response: writes at 0xFFFF then 0x0000.
REQ-033 The bench SHALL cover abort and restart:
- stimulus: start_in drops after 5 elements, then a new frame with base_addr=0x0200;
- response: no write and no done for the aborted frame, and the first write of the new frame is at 0x0200.
REQ-034 The bench SHALL cover reset mid-write:
- stimulus: reset_n=0 while write_enable=1 and write_ready=0;
- response: all outputs go to 0 immediately without waiting for a clock, with state IDLE and no done.

Source files
------------

// File: rtl/output_packer.sv
// Packs a stream of result elements into lane-masked write words,
// filling lanes from the top down and writing one word per full (or final) group.
module output_packer #(
  parameter int ELEM_W = 8,
  parameter int LANES  = 16,
  parameter int ADDR_W = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      start_in,
  input  logic [ADDR_W-1:0]         base_addr,
  input  logic                      result_valid,
  input  logic [ELEM_W-1:0]         result_in,
  input  logic                      last_in,
  output logic                      result_ready,
  output logic [ELEM_W*LANES-1:0]   write_bus,
  output logic [ADDR_W-1:0]         write_addr,
  output logic [LANES-1:0]          write_mask,
  output logic                      write_enable,
  input  logic                      write_ready,
  output logic                      done
);

  localparam int PTR_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam int BUS_W = ELEM_W * LANES;
  localparam logic [PTR_W-1:0] PTR_TOP = PTR_W'(LANES - 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    DONE
  } state_e;

  state_e             state_q, state_d;
  logic               start_q, start_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [BUS_W-1:0]   data_q, data_d;
  logic [LANES-1:0]   mask_q, mask_d;
  logic               last_q, last_d;
  logic               abort_q, abort_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      ptr_q   <= PTR_TOP;
      addr_q  <= '0;
      data_q  <= '0;
      mask_q  <= '0;
      last_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      start_q <= start_d;
      ptr_q   <= ptr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      last_q  <= last_d;
      abort_q <= abort_d;
    end
  end

  always_comb begin
    state_d = state_q;
    start_d = start_in;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    mask_d  = mask_q;
    last_d  = last_q;
    abort_d = abort_q;
    unique case (state_q)
      IDLE: begin
        if (start_in && !start_q) begin
          addr_d  = base_addr;
          ptr_d   = PTR_TOP;
          data_d  = '0;
          mask_d  = '0;
          last_d  = 1'b0;
          abort_d = 1'b0;
          state_d = FILL;
        end
      end
      FILL: begin
        // Dropping the frame enable discards the partial word outright.
        if (!start_in) begin
          data_d  = '0;
          mask_d  = '0;
          ptr_d   = PTR_TOP;
          state_d = IDLE;
        end else if (result_valid) begin
          data_d[ptr_q*ELEM_W +: ELEM_W] = result_in;
          mask_d[ptr_q] = 1'b1;
          if (ptr_q == '0 || last_in) begin
            last_d  = last_in;
            state_d = WRITE;
          end else begin
            ptr_d = ptr_q - PTR_W'(1);
          end
        end
      end
      WRITE: begin
        abort_d = abort_q | ~start_in;
        if (write_ready) begin
          addr_d  = addr_q + ADDR_W'(1);
          data_d  = '0;
          mask_d  = '0;
          ptr_d   = PTR_TOP;
          abort_d = 1'b0;
          if (abort_q || !start_in) begin
            state_d = IDLE;
          end else if (last_q) begin
            state_d = DONE;
          end else begin
            state_d = FILL;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign result_ready = (state_q == FILL);
  assign write_enable = (state_q == WRITE);
  assign done         = (state_q == DONE);
  assign write_bus    = write_enable ? data_q : '0;
  assign write_addr   = write_enable ? addr_q : '0;
  assign write_mask   = write_enable ? mask_q : '0;

endmodule

// File: tb/tb_output_packer.sv
// Randomized bench for output_packer: frames are fed element by element and
// the captured writes are compared to words built from the lane-filling rules.
module tb_output_packer;

  localparam int EW = 8;
  localparam int L  = 16;
  localparam int AW = 16;

  logic            clock = 1'b0;
  logic            reset_n = 1'b0;
  logic            start_in = 1'b0;
  logic [AW-1:0]   base_addr = '0;
  logic            result_valid = 1'b0;
  logic [EW-1:0]   result_in = '0;
  logic            last_in = 1'b0;
  logic            result_ready;
  logic [EW*L-1:0] write_bus;
  logic [AW-1:0]   write_addr;
  logic [L-1:0]    write_mask;
  logic            write_enable;
  logic            write_ready = 1'b1;
  logic            done;

  output_packer #(.ELEM_W(EW), .LANES(L), .ADDR_W(AW)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start_in(start_in),
    .base_addr(base_addr),
    .result_valid(result_valid),
    .result_in(result_in),
    .last_in(last_in),
    .result_ready(result_ready),
    .write_bus(write_bus),
    .write_addr(write_addr),
    .write_mask(write_mask),
    .write_enable(write_enable),
    .write_ready(write_ready),
    .done(done)
  );

  always #5 clock = ~clock;

  int vectors = 0;
  int miscompares = 0;
  int cycles = 0;
  int dones = 0;
  int bp_mode = 0;
  bit held = 1'b0;

  logic [AW-1:0]   got_addr[$];
  logic [L-1:0]    got_mask[$];
  logic [EW*L-1:0] got_bus[$];
  logic [AW-1:0]   exp_addr[$];
  logic [L-1:0]    exp_mask[$];
  logic [EW*L-1:0] exp_bus[$];
  logic [EW-1:0]   elems[$];

  logic [EW*L-1:0] hold_bus[5];
  logic [AW-1:0]   hold_addr[5];
  logic [L-1:0]    hold_mask[5];
  logic            hold_rr[5];

  always @(negedge clock) begin
    if (reset_n && write_enable && write_ready) begin
      got_addr.push_back(write_addr);
      got_mask.push_back(write_mask);
      got_bus.push_back(write_bus);
    end
    if (done) dones++;
  end

  initial begin
    #10000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clock);
    #1;
    cycles++;
    case (bp_mode)
      0: write_ready = 1'b1;
      1: write_ready = ($urandom_range(0, 2) != 0);
      2: write_ready = held;
      default: write_ready = 1'b0;
    endcase
  endtask

  task automatic fill_elems(input int n, input bit seq);
    elems.delete();
    for (int i = 0; i < n; i++)
      elems.push_back(seq ? EW'(i) : EW'($urandom));
  endtask

  // Expected words: element j of word k lands in lane L-1-j.
  task automatic build_model(input logic [AW-1:0] base, input int n);
    int words;
    int c;
    logic [L-1:0] m;
    logic [EW*L-1:0] b;
    exp_addr.delete();
    exp_mask.delete();
    exp_bus.delete();
    words = (n + L - 1) / L;
    for (int k = 0; k < words; k++) begin
      c = (n - k * L < L) ? n - k * L : L;
      m = '0;
      b = '0;
      for (int j = 0; j < c; j++) begin
        m[L-1-j] = 1'b1;
        b[(L-1-j)*EW +: EW] = elems[k*L+j];
      end
      exp_addr.push_back(base + AW'(k));
      exp_mask.push_back(m);
      exp_bus.push_back(b);
    end
  endtask

  task automatic feed_one(input logic [EW-1:0] e, input logic last, output bit ok);
    int gap;
    ok = 1'b0;
    if (bp_mode == 1) begin
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        result_valid = 1'b0;
        step();
      end
    end
    result_valid = 1'b1;
    result_in = e;
    last_in = last;
    for (int t = 0; t < 300 && !ok; t++) begin
      @(negedge clock);
      if (bp_mode == 2 && !held && write_enable) begin
        for (int h = 0; h < 5; h++) begin
          if (h > 0) @(negedge clock);
          hold_bus[h] = write_bus;
          hold_addr[h] = write_addr;
          hold_mask[h] = write_mask;
          hold_rr[h] = result_ready;
          step();
        end
        held = 1'b1;
        write_ready = 1'b1;
        continue;
      end
      ok = result_ready;
      step();
    end
    result_valid = 1'b0;
    last_in = 1'b0;
  endtask

  task automatic run_frame(input logic [AW-1:0] base, input int n, output bit ok);
    bit k;
    ok = 1'b1;
    base_addr = base;
    start_in = 1'b1;
    for (int i = 0; i < n; i++) begin
      feed_one(elems[i], (i == n - 1), k);
      ok &= k;
    end
    repeat (40) step();
    start_in = 1'b0;
    step();
    step();
  endtask

  task automatic test_reset();
    #3;
    vectors++;
    if ({result_ready, write_enable, done} !== 3'b000 || write_bus !== '0 ||
        write_addr !== '0 || write_mask !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got rr=%b we=%b done=%b addr=%h mask=%h, expected all 0",
               result_ready, write_enable, done, write_addr, write_mask);
    end
    start_in = 1'b1;
    @(negedge clock);
    reset_n = 1'b1;
    @(negedge clock);
    vectors++;
    if (result_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_start_held: got result_ready=%b, expected 1", result_ready);
    end
    @(posedge clock);
    #1;
    start_in = 1'b0;
    repeat (3) step();
    vectors++;
    if (got_addr.size() != 0 || dones != 0 || result_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_abort: got writes=%0d dones=%0d rr=%b, expected 0 0 0",
               got_addr.size(), dones, result_ready);
    end
  endtask

  task automatic test_full_word();
    int w0 = got_addr.size();
    int d0 = dones;
    bit ok;
    logic [EW*L-1:0] b;
    bp_mode = 0;
    fill_elems(16, 1'b1);
    build_model(16'h8000, 16);
    run_frame(16'h8000, 16, ok);
    vectors++;
    if (!ok || got_addr.size() - w0 != 1) begin
      miscompares++;
      $display("FAIL full_count: got %0d writes ok=%b, expected 1 write", got_addr.size() - w0, ok);
    end else begin
      b = got_bus[w0];
      vectors++;
      if (got_addr[w0] !== 16'h8000 || got_mask[w0] !== 16'hFFFF ||
          b[127:120] !== 8'h00 || b[7:0] !== 8'h0F || b !== exp_bus[0]) begin
        miscompares++;
        $display("FAIL full_word: got addr=%h mask=%h bus=%h, expected addr=8000 mask=ffff bus=%h",
                 got_addr[w0], got_mask[w0], b, exp_bus[0]);
      end
    end
    vectors++;
    if (dones - d0 != 1) begin
      miscompares++;
      $display("FAIL full_done: got %0d done pulses, expected 1", dones - d0);
    end
  endtask

  task automatic test_partial();
    int w0 = got_addr.size();
    int d0 = dones;
    bit ok;
    logic [EW*L-1:0] b;
    bp_mode = 0;
    fill_elems(20, 1'b0);
    build_model(16'h0100, 20);
    run_frame(16'h0100, 20, ok);
    vectors++;
    if (!ok || got_addr.size() - w0 != 2) begin
      miscompares++;
      $display("FAIL partial_count: got %0d writes ok=%b, expected 2", got_addr.size() - w0, ok);
    end else begin
      for (int k = 0; k < 2; k++) begin
        vectors++;
        if (got_addr[w0+k] !== exp_addr[k] || got_mask[w0+k] !== exp_mask[k] ||
            got_bus[w0+k] !== exp_bus[k]) begin
          miscompares++;
          $display("FAIL partial_word%0d: got addr=%h mask=%h bus=%h, expected addr=%h mask=%h bus=%h",
                   k, got_addr[w0+k], got_mask[w0+k], got_bus[w0+k], exp_addr[k], exp_mask[k], exp_bus[k]);
        end
      end
      b = got_bus[w0+1];
      vectors++;
      if (got_mask[w0+1] !== 16'hF000 || b[95:0] !== '0 || got_addr[w0+1] !== 16'h0101) begin
        miscompares++;
        $display("FAIL partial_tail: got addr=%h mask=%h low=%h, expected addr=0101 mask=f000 low=0",
                 got_addr[w0+1], got_mask[w0+1], b[95:0]);
      end
    end
    vectors++;
    if (dones - d0 != 1) begin
      miscompares++;
      $display("FAIL partial_done: got %0d done pulses, expected 1", dones - d0);
    end
  endtask

  task automatic test_backpressure();
    int w0 = got_addr.size();
    bit ok;
    bp_mode = 2;
    held = 1'b0;
    write_ready = 1'b0;
    fill_elems(20, 1'b0);
    build_model(16'h0300, 20);
    run_frame(16'h0300, 20, ok);
    vectors++;
    if (!held) begin
      miscompares++;
      $display("FAIL bp_hold: got held=0, expected a held write");
    end else begin
      for (int h = 0; h < 5; h++) begin
        vectors++;
        if (hold_bus[h] !== exp_bus[0] || hold_addr[h] !== exp_addr[0] ||
            hold_mask[h] !== exp_mask[0] || hold_rr[h] !== 1'b0) begin
          miscompares++;
          $display("FAIL bp_stable%0d: got addr=%h mask=%h rr=%b, expected addr=%h mask=%h rr=0",
                   h, hold_addr[h], hold_mask[h], hold_rr[h], exp_addr[0], exp_mask[0]);
        end
      end
    end
    vectors++;
    if (!ok || got_addr.size() - w0 != exp_addr.size()) begin
      miscompares++;
      $display("FAIL bp_count: got %0d writes ok=%b, expected %0d", got_addr.size() - w0, ok, exp_addr.size());
    end else begin
      foreach (exp_addr[k]) begin
        vectors++;
        if (got_addr[w0+k] !== exp_addr[k] || got_mask[w0+k] !== exp_mask[k] ||
            got_bus[w0+k] !== exp_bus[k]) begin
          miscompares++;
          $display("FAIL bp_word%0d: got addr=%h mask=%h bus=%h, expected addr=%h mask=%h bus=%h",
                   k, got_addr[w0+k], got_mask[w0+k], got_bus[w0+k], exp_addr[k], exp_mask[k], exp_bus[k]);
        end
      end
    end
    bp_mode = 0;
  endtask

  task automatic test_wrap();
    int w0 = got_addr.size();
    bit ok;
    bp_mode = 1;
    fill_elems(32, 1'b0);
    build_model(16'hFFFF, 32);
    run_frame(16'hFFFF, 32, ok);
    vectors++;
    if (!ok || got_addr.size() - w0 != 2) begin
      miscompares++;
      $display("FAIL wrap_count: got %0d writes ok=%b, expected 2", got_addr.size() - w0, ok);
    end else begin
      vectors++;
      if (got_addr[w0] !== 16'hFFFF || got_addr[w0+1] !== 16'h0000 ||
          got_bus[w0] !== exp_bus[0] || got_bus[w0+1] !== exp_bus[1]) begin
        miscompares++;
        $display("FAIL wrap_addr: got %h then %h, expected ffff then 0000 with matching data",
                 got_addr[w0], got_addr[w0+1]);
      end
    end
    bp_mode = 0;
  endtask

  task automatic test_abort_restart();
    int w0 = got_addr.size();
    int d0 = dones;
    bit ok;
    bit k;
    bp_mode = 0;
    fill_elems(10, 1'b0);
    base_addr = 16'h0500;
    start_in = 1'b1;
    for (int i = 0; i < 5; i++) feed_one(elems[i], 1'b0, k);
    start_in = 1'b0;
    repeat (6) step();
    vectors++;
    if (got_addr.size() != w0 || dones != d0 || result_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL abort_quiet: got writes=%0d dones=%0d rr=%b, expected 0 0 0",
               got_addr.size() - w0, dones - d0, result_ready);
    end
    fill_elems(16, 1'b0);
    build_model(16'h0200, 16);
    run_frame(16'h0200, 16, ok);
    vectors++;
    if (!ok || got_addr.size() - w0 != 1) begin
      miscompares++;
      $display("FAIL restart_count: got %0d writes ok=%b, expected 1", got_addr.size() - w0, ok);
    end else if (got_addr[w0] !== 16'h0200 || got_bus[w0] !== exp_bus[0] || got_mask[w0] !== 16'hFFFF) begin
      miscompares++;
      $display("FAIL restart_word: got addr=%h mask=%h, expected addr=0200 mask=ffff", got_addr[w0], got_mask[w0]);
    end
    vectors++;
    if (dones - d0 != 1) begin
      miscompares++;
      $display("FAIL restart_done: got %0d done pulses, expected 1", dones - d0);
    end
  endtask

  task automatic test_back_to_back();
    int w0 = got_addr.size();
    int c0;
    bit k;
    bit ok = 1'b1;
    logic [AW-1:0] base = AW'($urandom);
    bp_mode = 0;
    fill_elems(32, 1'b0);
    build_model(base, 32);
    base_addr = base;
    start_in = 1'b1;
    c0 = cycles;
    for (int i = 0; i < 32; i++) begin
      feed_one(elems[i], (i == 31), k);
      ok &= k;
    end
    vectors++;
    if (!ok || cycles - c0 > 2 * L + 2) begin
      miscompares++;
      $display("FAIL b2b_rate: got %0d cycles ok=%b, expected at most %0d", cycles - c0, ok, 2 * L + 2);
    end
    repeat (10) step();
    start_in = 1'b0;
    step();
    step();
    vectors++;
    if (got_addr.size() - w0 != 2 || got_addr[w0+1] !== exp_addr[1] || got_bus[w0] !== exp_bus[0] ||
        got_bus[w0+1] !== exp_bus[1]) begin
      miscompares++;
      $display("FAIL b2b_words: got %0d writes, expected 2 matching words at %h", got_addr.size() - w0, base);
    end
  endtask

  task automatic test_random();
    int n;
    int w0;
    int d0;
    bit ok;
    logic [AW-1:0] base;
    bp_mode = 1;
    for (int f = 0; f < 5; f++) begin
      n = $urandom_range(1, 48);
      base = AW'($urandom);
      w0 = got_addr.size();
      d0 = dones;
      fill_elems(n, 1'b0);
      build_model(base, n);
      run_frame(base, n, ok);
      vectors++;
      if (!ok || got_addr.size() - w0 != exp_addr.size() || dones - d0 != 1) begin
        miscompares++;
        $display("FAIL rand%0d_count: n=%0d got %0d writes %0d dones, expected %0d writes 1 done",
                 f, n, got_addr.size() - w0, dones - d0, exp_addr.size());
      end else begin
        foreach (exp_addr[k]) begin
          vectors++;
          if (got_addr[w0+k] !== exp_addr[k] || got_mask[w0+k] !== exp_mask[k] ||
              got_bus[w0+k] !== exp_bus[k]) begin
            miscompares++;
            $display("FAIL rand%0d_word%0d: got addr=%h mask=%h, expected addr=%h mask=%h",
                     f, k, got_addr[w0+k], got_mask[w0+k], exp_addr[k], exp_mask[k]);
          end
        end
      end
    end
    bp_mode = 0;
  endtask

  task automatic test_reset_mid_write();
    int w0 = got_addr.size();
    int d0;
    bit k;
    bp_mode = 3;
    write_ready = 1'b0;
    fill_elems(16, 1'b0);
    base_addr = 16'h0400;
    start_in = 1'b1;
    for (int i = 0; i < 16; i++) feed_one(elems[i], 1'b0, k);
    @(negedge clock);
    vectors++;
    if (write_enable !== 1'b1) begin
      miscompares++;
      $display("FAIL rst_pending: got write_enable=%b, expected 1", write_enable);
    end
    #2;
    reset_n = 1'b0;
    start_in = 1'b0;
    d0 = dones;
    #1;
    vectors++;
    if ({result_ready, write_enable, done} !== 3'b000 || write_bus !== '0 ||
        write_addr !== '0 || write_mask !== '0) begin
      miscompares++;
      $display("FAIL rst_async: got rr=%b we=%b done=%b addr=%h mask=%h, expected all 0",
               result_ready, write_enable, done, write_addr, write_mask);
    end
    repeat (3) step();
    @(negedge clock);
    reset_n = 1'b1;
    bp_mode = 0;
    repeat (5) step();
    vectors++;
    if (got_addr.size() != w0 || dones != d0 || write_enable !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_abandon: got writes=%0d dones=%0d we=%b, expected 0 0 0",
               got_addr.size() - w0, dones - d0, write_enable);
    end
  endtask

  initial begin
    test_reset();
    test_full_word();
    test_partial();
    test_backpressure();
    test_wrap();
    test_abort_restart();
    test_back_to_back();
    test_random();
    test_reset_mid_write();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
